chacha_stream_core: RTL and testbench

- Parametrised successor to the small-scale ChaCha20 encrypter.
- Holds a 16-word ChaCha state of W-bit words and runs the configured number of rounds iteratively, one quarter-round per cycle.
- Streams W-bit plaintext words through a valid/ready interface, XORing each with the keystream and auto-incrementing the block counter between blocks.
- Sits between the key/nonce load logic and the serial/parallel I/O adapters.

---
 rtl/chacha_pkg.sv | 31 +++
 rtl/chacha_qr.sv | 39 +++
 rtl/chacha_stream_core.sv | 165 ++++++++++++++++
 tb/tb_chacha_stream_core.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// chacha_pkg: shared FSM state type, sigma constants, quarter-round index tables
// and the W-bit left-rotate helper used by the ChaCha stream core.
package chacha_pkg;

    typedef enum logic [1:0] {IDLE, GEN, ADD, STREAM} state_t;

    localparam logic [31:0] SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

    localparam logic [3:0] COL_IDX [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };

    localparam logic [3:0] DIAG_IDX [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    // Rotate left by n within the low w bits; bits above w are returned as zero.
    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n,
                                         input int unsigned w = 32);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return ((x << n) | ((x & mask) >> (w - n))) & mask;
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// chacha_qr: combinational ChaCha quarter-round on W-bit words with
// configurable rotate amounts R1..R4.
module chacha_qr
    import chacha_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned R1 = 4,
    parameter int unsigned R2 = 3,
    parameter int unsigned R3 = 2,
    parameter int unsigned R4 = 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b,
    output logic [W-1:0] o_c,
    output logic [W-1:0] o_d
);

    logic [W-1:0] w_a1, w_b1, w_c1, w_d1;
    logic [W-1:0] w_a2, w_b2, w_c2, w_d2;

    assign w_a1 = i_a + i_b;
    assign w_d1 = W'(rotl(32'(i_d ^ w_a1), R1, W));
    assign w_c1 = i_c + w_d1;
    assign w_b1 = W'(rotl(32'(i_b ^ w_c1), R2, W));
    assign w_a2 = w_a1 + w_b1;
    assign w_d2 = W'(rotl(32'(w_d1 ^ w_a2), R3, W));
    assign w_c2 = w_c1 + w_d2;
    assign w_b2 = W'(rotl(32'(w_b1 ^ w_c2), R4, W));

    assign o_a = w_a2;
    assign o_b = w_b2;
    assign o_c = w_c2;
    assign o_d = w_d2;

endmodule

// File: rtl/chacha_stream_core.sv
// chacha_stream_core: iterative ChaCha keystream generator (one quarter-round per cycle)
// XORing a valid/ready word stream. Optional macro CHACHA_CTR_WRAP_ERR_EN: counter wrap halts with sticky err.
module chacha_stream_core
    import chacha_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned ROUNDS = 8,
    parameter int unsigned R1     = 4,
    parameter int unsigned R2     = 3,
    parameter int unsigned R3     = 2,
    parameter int unsigned R4     = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           lock,
    input  logic [8*W-1:0] key,
    input  logic [3*W-1:0] nonce,
    input  logic [W-1:0]   init_value,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           busy,
    output logic           err
);

    localparam int unsigned NQR = 4 * ROUNDS;

    state_t         r_state;
    logic [8*W-1:0] r_key;
    logic [3*W-1:0] r_nonce;
    logic [W-1:0]   r_ctr;
    logic [W-1:0]   r_work [16];
    logic [6:0]     r_step;
    logic [3:0]     r_idx;
    logic           r_out_valid;
    logic [W-1:0]   r_out_data;

    logic [8*W-1:0] w_src_key;
    logic [3*W-1:0] w_src_nonce;
    logic [W-1:0]   w_src_ctr;
    logic [W-1:0]   w_init [16];
    logic [3:0]     w_sel [4];
    logic [W-1:0]   w_qa, w_qb, w_qc, w_qd;
    logic           w_accept;

    // Initial state comes from the ports on lock, else from the held registers
    // (with the counter already advanced when rolling over to the next block).
    always_comb begin
        w_src_key   = lock ? key   : r_key;
        w_src_nonce = lock ? nonce : r_nonce;
        w_src_ctr   = lock ? init_value : ((r_state == STREAM) ? r_ctr + W'(1) : r_ctr);
        for (int unsigned i = 0; i < 4; i++) w_init[i] = SIGMA[i][W-1:0];
        for (int unsigned i = 0; i < 8; i++) w_init[4+i] = w_src_key[W*i +: W];
        w_init[12] = w_src_ctr;
        for (int unsigned i = 0; i < 3; i++) w_init[13+i] = w_src_nonce[W*i +: W];
    end

    always_comb begin
        for (int unsigned j = 0; j < 4; j++)
            w_sel[j] = r_step[2] ? DIAG_IDX[r_step[1:0]][j] : COL_IDX[r_step[1:0]][j];
    end

    chacha_qr #(.W(W), .R1(R1), .R2(R2), .R3(R3), .R4(R4)) u_qr (
        .i_a(r_work[w_sel[0]]),
        .i_b(r_work[w_sel[1]]),
        .i_c(r_work[w_sel[2]]),
        .i_d(r_work[w_sel[3]]),
        .o_a(w_qa),
        .o_b(w_qb),
        .o_c(w_qc),
        .o_d(w_qd)
    );

    assign in_ready  = (r_state == STREAM) && (!r_out_valid || out_ready) && !lock;
    assign w_accept  = in_ready && in_valid;
    assign busy      = (r_state == GEN);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_nonce <= '0;
            r_ctr   <= '0;
            r_step  <= '0;
            r_idx   <= '0;
            for (int unsigned i = 0; i < 16; i++) r_work[i] <= '0;
        end else if (lock) begin
            r_state <= GEN;
            r_key   <= key;
            r_nonce <= nonce;
            r_ctr   <= init_value;
            r_step  <= '0;
            r_idx   <= '0;
            for (int unsigned i = 0; i < 16; i++) r_work[i] <= w_init[i];
        end else begin
            case (r_state)
                GEN: begin
                    r_work[w_sel[0]] <= w_qa;
                    r_work[w_sel[1]] <= w_qb;
                    r_work[w_sel[2]] <= w_qc;
                    r_work[w_sel[3]] <= w_qd;
                    r_step <= r_step + 7'd1;
                    if (r_step == 7'(NQR - 1)) r_state <= ADD;
                end
                ADD: begin
                    for (int unsigned i = 0; i < 16; i++) r_work[i] <= r_work[i] + w_init[i];
                    r_state <= STREAM;
                end
                STREAM: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 4'd1;
                        if (r_idx == 4'd15) begin
                            r_ctr  <= r_ctr + W'(1);
                            r_step <= '0;
`ifdef CHACHA_CTR_WRAP_ERR_EN
                            if (r_ctr == '1) begin
                                r_state <= IDLE;
                            end else begin
                                r_state <= GEN;
                                for (int unsigned i = 0; i < 16; i++) r_work[i] <= w_init[i];
                            end
`else
                            r_state <= GEN;
                            for (int unsigned i = 0; i < 16; i++) r_work[i] <= w_init[i];
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output register drains independently of lock so pending ciphertext is never dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data ^ r_work[r_idx];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef CHACHA_CTR_WRAP_ERR_EN
    logic r_err;
    always_ff @(posedge clk) begin
        if (reset || lock)
            r_err <= 1'b0;
        else if (w_accept && r_idx == 4'd15 && r_ctr == '1)
            r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_chacha_stream_core.sv
// tb_chacha_stream_core: directed bench with a spec-level ChaCha block model and a
// scoreboard of expected ciphertext checked on every output transfer.
module tb_chacha_stream_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lock = 1'b0;
    logic [63:0] key = '0;
    logic [23:0] nonce = '0;
    logic [7:0]  init_value = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
    localparam logic [23:0] N1 = 24'hC3A501;
    localparam logic [63:0] K2 = 64'hFEDCBA9876543210;
    localparam logic [23:0] N2 = 24'h123456;
    localparam logic [63:0] K3 = 64'h0F1E2D3C4B5A6978;
    localparam logic [23:0] N3 = 24'h5AA5C3;

    always #5 clk = ~clk;

    chacha_stream_core #(.W(8), .ROUNDS(8), .R1(4), .R2(3), .R3(2), .R4(1)) dut (
        .clk(clk), .reset(reset), .lock(lock), .key(key), .nonce(nonce),
        .init_value(init_value), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .err(err)
    );

    // ---------------- reference model ----------------
    logic [7:0]   m_x [16];
    logic [63:0]  m_key;
    logic [23:0]  m_nonce;
    logic [7:0]   m_ctr;
    int           m_idx;
    logic [127:0] m_ks;
    logic [7:0]   exp_q [$];
    logic [7:0]   got_q [$];

    function automatic logic [7:0] rot8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v};
        return t[15-n -: 8];
    endfunction

    function automatic void qrx(input int a, input int b, input int c, input int d);
        m_x[a] = m_x[a] + m_x[b]; m_x[d] = rot8(m_x[d] ^ m_x[a], 4);
        m_x[c] = m_x[c] + m_x[d]; m_x[b] = rot8(m_x[b] ^ m_x[c], 3);
        m_x[a] = m_x[a] + m_x[b]; m_x[d] = rot8(m_x[d] ^ m_x[a], 2);
        m_x[c] = m_x[c] + m_x[d]; m_x[b] = rot8(m_x[b] ^ m_x[c], 1);
    endfunction

    function automatic logic [127:0] mblock(input logic [63:0] k, input logic [23:0] n,
                                            input logic [7:0] c, input int rounds);
        logic [7:0]   init [16];
        logic [127:0] res;
        init[0] = 8'h65; init[1] = 8'h6e; init[2] = 8'h32; init[3] = 8'h74;
        for (int j = 0; j < 8; j++) init[4+j] = k[8*j +: 8];
        init[12] = c;
        for (int j = 0; j < 3; j++) init[13+j] = n[8*j +: 8];
        for (int i = 0; i < 16; i++) m_x[i] = init[i];
        for (int r = 0; r < rounds; r++) begin
            if (r % 2 == 0) begin
                qrx(0, 4, 8, 12); qrx(1, 5, 9, 13); qrx(2, 6, 10, 14); qrx(3, 7, 11, 15);
            end else begin
                qrx(0, 5, 10, 15); qrx(1, 6, 11, 12); qrx(2, 7, 8, 13); qrx(3, 4, 9, 14);
            end
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = m_x[i] + init[i];
        return res;
    endfunction

    task automatic model_lock(input logic [63:0] k, input logic [23:0] n, input logic [7:0] c);
        m_key = k; m_nonce = n; m_ctr = c; m_idx = 0;
        m_ks = mblock(k, n, c, 8);
    endtask

    task automatic model_accept(input logic [7:0] w);
        exp_q.push_back(w ^ m_ks[8*m_idx +: 8]);
        m_idx++;
        if (m_idx == 16) begin
            m_idx = 0;
            m_ctr = m_ctr + 8'd1;
            m_ks = mblock(m_key, m_nonce, m_ctr, 8);
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL ct_unexpected: got %0h expected no word", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL ct_word: got %0h expected %0h", out_data, e);
                end
            end
            got_q.push_back(out_data);
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic do_lock(input logic [63:0] k, input logic [23:0] n, input logic [7:0] c);
        key = k; nonce = n; init_value = c; lock = 1'b1;
        model_lock(k, n, c);
        @(posedge clk); #1;
        lock = 1'b0;
    endtask

    task automatic send(input logic [7:0] w);
        bit acc = 1'b0;
        in_valid = 1'b1; in_data = w;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("FAIL send_timeout: word %0h accepted 0 required 1", w);
        end else begin
            model_accept(w);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] blk;
        logic [7:0]   ct [32];
        int           busy_cnt;
        int           first_rdy;

        // model pins: hand-computed quarter-round and zero-round block
        for (int i = 0; i < 16; i++) m_x[i] = 8'h00;
        m_x[0] = 8'h01;
        qrx(0, 1, 2, 3);
        check("pin_qr_a", m_x[0], 8'h81);
        check("pin_qr_b", m_x[1], 8'hAD);
        check("pin_qr_c", m_x[2], 8'h56);
        check("pin_qr_d", m_x[3], 8'h46);
        blk = mblock(K1, N1, 8'h01, 0);
        check("pin_blk0_s0", blk[7:0], 8'hCA);
        check("pin_blk0_s4", blk[39:32], 8'hDE);
        check("pin_blk0_s12", blk[103:96], 8'h02);

        // reset with all inputs 0
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);
        @(posedge clk); #1;

        // lock latency: busy for 32 cycles, in_ready first at cycle 34
        key = K1; nonce = N1; init_value = 8'h01; lock = 1'b1;
        model_lock(K1, N1, 8'h01);
        @(posedge clk); #1;
        lock = 1'b0;
        busy_cnt = 0; first_rdy = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (in_ready && first_rdy < 0) first_rdy = k;
        end
        check("busy_cycles", busy_cnt, 32);
        check("first_in_ready_cycle", first_rdy, 34);
        @(posedge clk); #1;

        // zero plaintext: keystream blocks 1 and 2
        for (int i = 0; i < 32; i++) send(8'h00);
        drain();

        // ramp encrypt, then decrypt with the same key/nonce/counter
        got_q.delete();
        do_lock(K1, N1, 8'h01);
        for (int i = 0; i < 32; i++) send(8'(i));
        drain();
        check("ramp_ct_count", got_q.size(), 32);
        for (int i = 0; i < 32; i++) ct[i] = (i < got_q.size()) ? got_q[i] : 8'h00;
        got_q.delete();
        do_lock(K1, N1, 8'h01);
        for (int i = 0; i < 32; i++) send(ct[i]);
        drain();
        check("ramp_pt_count", got_q.size(), 32);
        for (int i = 0; i < 32 && i < got_q.size(); i++) check("ramp_roundtrip", got_q[i], 8'(i));

        // output stall with a word pending
        do_lock(K2, N2, 8'h05);
        out_ready = 1'b0;
        send(8'h11);
        in_valid = 1'b1; in_data = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, exp_q[0]);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) send(8'h22 + 8'(i));
        drain();

        // lock at stream index 7 with in_valid high
        do_lock(K2, N2, 8'h09);
        for (int i = 0; i < 7; i++) send(8'h30 + 8'(i));
        key = K3; nonce = N3; init_value = 8'h40; lock = 1'b1;
        in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        check("lock_in_ready", in_ready, 0);
        @(posedge clk); #1;
        lock = 1'b0; in_valid = 1'b0;
        model_lock(K3, N3, 8'h40);
        @(negedge clk);
        check("lock_busy_next", busy, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i));
        drain();

        // counter wrap from 8'hFF
        do_lock(K1, N1, 8'hFF);
        for (int i = 0; i < 16; i++) send(8'hC0 + 8'(i));
`ifdef CHACHA_CTR_WRAP_ERR_EN
        drain();
        @(negedge clk);
        check("wrap_err", err, 1);
        check("wrap_busy", busy, 0);
        first_rdy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) first_rdy = 1;
        end
        check("wrap_in_ready_held", first_rdy, 0);
        @(posedge clk); #1;
        do_lock(K1, N1, 8'h01);
        @(negedge clk);
        check("wrap_err_cleared", err, 0);
        @(posedge clk); #1;
`else
        @(negedge clk);
        check("wrap_err_zero", err, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) send(8'hD0 + 8'(i));
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
